quad_encoder_multi: RTL and testbench
=====================================

// Module: quad_encoder_multi
// PURPOSE
//   Parametrised N-channel quadrature rotary-encoder decoder for the DE10-Lite.
//   Per channel: 2-flop synchroniser, glitch filter, Gray-code state tracker,
//   selectable x1/x2/x4 resolution, signed position counter (wrap or saturate),
//   direction, step pulse and sticky illegal-transition flag.
//   Sits between the encoder pins (ARDUINO_IO pairs) and display/control logic.
// PARAMETERS
//   NUM_CH      2   number of independent encoder channels (>=1)
//   COUNT_W     8   width of each signed two's-complement position counter (>=2)
//   FILTER_LEN  4   consecutive identical synced samples required to accept a new AB state (>=1)
//   RESOLUTION  4   counts per Gray cycle: 1, 2 or 4
//   SATURATE    0   0 = counter wraps, 1 = counter clamps at signed min/max
// PORTS
//   MAX10_CLK1_50  in   1               system clock (50 MHz), all logic on rising edge
//   reset          in   1               synchronous, active-high reset
//   enc_a          in   NUM_CH          raw A input per channel (asynchronous)
//   enc_b          in   NUM_CH          raw B input per channel (asynchronous)
//   clr            in   NUM_CH          synchronous per-channel clear of count and err
//   count          out  NUM_CH*COUNT_W  packed signed counts, ch i at [i*COUNT_W +: COUNT_W]
//   step           out  NUM_CH          one-cycle pulse when the count changes (or would, if saturated)
//   dir            out  NUM_CH          direction of last accepted step: 1 = A leads B (+), 0 = B leads A (-)
//   err            out  NUM_CH          sticky: illegal transition seen (both A and B changed)
// BEHAVIOUR
//   Reset: sync regs, filter counter, count, step, dir, err = 0; per-channel init flag set.
//   Sync: s1 <= {enc_a,enc_b}; s2 <= s1. Filtered state ab_q is {A,B}.
//   Filter: counter increments each cycle s2 != ab_q, clears whenever s2 == ab_q or s2 changes.
//     On the FILTER_LEN-th consecutive mismatch, ab_q <= s2 and decode happens on that edge.
//     Latency: stable input change -> count/step update = FILTER_LEN+2 clock edges.
//   Init: first accepted state after reset loads ab_q only; no step, no count, no err; clears init.
//   Decode ({A,B}): 00->10->11->01->00 = +1 direction; reverse = -1 direction.
//     x4: every legal transition counts. x2: only entries into 00 or 11 count.
//     x1: only entry into 00 counts. Non-counting legal transitions update dir only.
//     Both bits changed (00<->11, 10<->01): no count, no step, dir unchanged, err <= 1.
//   Counter: SATURATE=0 wraps (2^(W-1)-1 +1 -> -2^(W-1), and reverse).
//     SATURATE=1 holds at max/min; step still pulses, dir still updates.
//   step high exactly one cycle per counting transition; low otherwise.
//   clr[i]: count <= 0, err <= 0 next edge; wins over a same-cycle step or illegal event
//     (step/dir still report that event). clr does not disturb sync/filter/ab_q.
//   reset mid-operation: all state returns to reset values at the next edge; wins over clr.
//   Channels fully independent; no shared state.
// TESTING
//   1 NUM_CH=2, FILTER_LEN=4, x4: reset, ch0 AB 00->10->11->01->00, each held 10 clk
//       -> count0 = 1,2,3,4; 4 step pulses, each 6 edges after change; dir0=1; ch1 stays 0.
//   2 From count0=0 drive reverse 00->01->11->10->00 -> count0 = 0xFF,0xFE,0xFD,0xFC; dir0=0.
//   3 Glitch: A high for 3 clk (< FILTER_LEN) then low -> no step, count and ab_q unchanged.
//   4 COUNT_W=8: drive to +127 then one + step -> SATURATE=0: -128 (0x80);
//       SATURATE=1: stays 127, step pulses.
//   5 Illegal 00->11 -> err0=1 (sticky over further legal steps), count unchanged;
//       pulse clr0 -> count0=0, err0=0.
//   6 Reset for 2 clk with encoder held at 11, release -> first accepted state gives
//       no step/err; then 11->01 counts +1 (x4), x1 counts only on return to 00.

Source files
------------

// File: rtl/quad_encoder_multi.sv
// quad_encoder_multi
// N-channel quadrature encoder decoder: per channel a 2-flop synchroniser,
// a glitch filter, Gray-code transition decode with x1/x2/x4 resolution,
// a signed wrap/saturate position counter, direction, step pulse and a
// sticky illegal-transition flag. Channels share no state.
module quad_encoder_multi #(
  parameter int NUM_CH     = 2,
  parameter int COUNT_W    = 8,
  parameter int FILTER_LEN = 4,
  parameter int RESOLUTION = 4,
  parameter int SATURATE   = 0
) (
  input  logic                        MAX10_CLK1_50,
  input  logic                        reset,
  input  logic [NUM_CH-1:0]           enc_a,
  input  logic [NUM_CH-1:0]           enc_b,
  input  logic [NUM_CH-1:0]           clr,
  output logic [NUM_CH*COUNT_W-1:0]   count,
  output logic [NUM_CH-1:0]           step,
  output logic [NUM_CH-1:0]           dir,
  output logic [NUM_CH-1:0]           err
);

  // Filter counter must reach FILTER_LEN during the initial lock-on phase.
  localparam int                  FCNT_W   = $clog2(FILTER_LEN + 32'sd1) + 32'sd1;
  localparam logic [FCNT_W-1:0]   FLT_LAST = FCNT_W'(FILTER_LEN - 32'sd1);
  localparam logic [FCNT_W-1:0]   FLT_INIT = FCNT_W'(FILTER_LEN);
  localparam logic [FCNT_W-1:0]   FCNT_ONE = FCNT_W'(32'sd1);
  localparam logic [FCNT_W-1:0]   FCNT_ZERO = FCNT_W'(32'sd0);
  localparam logic [COUNT_W-1:0]  CNT_MAX  = {1'b0, {(COUNT_W-1){1'b1}}};
  localparam logic [COUNT_W-1:0]  CNT_MIN  = {1'b1, {(COUNT_W-1){1'b0}}};
  localparam logic [COUNT_W-1:0]  CNT_ONE  = COUNT_W'(32'sd1);
  localparam logic [COUNT_W-1:0]  CNT_ZERO = COUNT_W'(32'sd0);
  localparam logic                SAT_EN   = (SATURATE != 32'sd0);

  // Position of an {A,B} state along the forward Gray cycle 00,10,11,01.
  function automatic logic [1:0] gray_pos(input logic [1:0] ab);
    logic [1:0] pos;
    case (ab)
      2'b00:   pos = 2'd0;
      2'b10:   pos = 2'd1;
      2'b11:   pos = 2'd2;
      2'b01:   pos = 2'd3;
      default: pos = 2'd0;
    endcase
    return pos;
  endfunction

  // Whether a legal transition into state ab produces a count at this resolution.
  function automatic logic counts_here(input logic [1:0] ab);
    logic hit;
    if (RESOLUTION == 32'sd4) begin
      hit = 1'b1;
    end else if (RESOLUTION == 32'sd2) begin
      hit = (ab == 2'b00) || (ab == 2'b11);
    end else begin
      hit = (ab == 2'b00);
    end
    return hit;
  endfunction

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [1:0]         s1_r;
    logic [1:0]         s2_r;
    logic [1:0]         ab_r;
    logic [FCNT_W-1:0]  fcnt_r;
    logic [FCNT_W-1:0]  fcnt_nxt_s;
    logic               init_r;
    logic               accept_s;
    logic [1:0]         delta_s;
    logic               count_ev_s;
    logic               illegal_s;
    logic               dir_nxt_s;
    logic [COUNT_W-1:0] count_r;
    logic [COUNT_W-1:0] count_nxt_s;
    logic               step_r;
    logic               dir_r;
    logic               err_r;

    // Glitch filter: accept s2 once it has differed from ab for FILTER_LEN
    // straight cycles; while locking on after reset, accept any s2 that has
    // been stable for FILTER_LEN+1 cycles so the power-up state is learned.
    always_comb begin
      fcnt_nxt_s = fcnt_r;
      accept_s   = 1'b0;
      if (s1_r != s2_r) begin
        fcnt_nxt_s = FCNT_ZERO;
      end else if (init_r) begin
        if (fcnt_r == FLT_INIT) begin
          accept_s   = 1'b1;
          fcnt_nxt_s = FCNT_ZERO;
        end else begin
          fcnt_nxt_s = fcnt_r + FCNT_ONE;
        end
      end else if (s2_r == ab_r) begin
        fcnt_nxt_s = FCNT_ZERO;
      end else if (fcnt_r == FLT_LAST) begin
        accept_s   = 1'b1;
        fcnt_nxt_s = FCNT_ZERO;
      end else begin
        fcnt_nxt_s = fcnt_r + FCNT_ONE;
      end
    end

    // Transition decode: one step forward/back is legal, two steps is illegal.
    always_comb begin
      delta_s    = gray_pos(s2_r) - gray_pos(ab_r);
      count_ev_s = 1'b0;
      illegal_s  = 1'b0;
      dir_nxt_s  = dir_r;
      if (accept_s && !init_r) begin
        case (delta_s)
          2'd1: begin
            dir_nxt_s  = 1'b1;
            count_ev_s = counts_here(s2_r);
          end
          2'd3: begin
            dir_nxt_s  = 1'b0;
            count_ev_s = counts_here(s2_r);
          end
          2'd2: begin
            illegal_s  = 1'b1;
          end
          default: begin
            count_ev_s = 1'b0;
            illegal_s  = 1'b0;
          end
        endcase
      end else begin
        count_ev_s = 1'b0;
        illegal_s  = 1'b0;
      end
    end

    // Next position: wrap naturally or clamp at the signed limits.
    always_comb begin
      count_nxt_s = count_r;
      if (count_ev_s && dir_nxt_s) begin
        if (SAT_EN && (count_r == CNT_MAX)) begin
          count_nxt_s = count_r;
        end else begin
          count_nxt_s = count_r + CNT_ONE;
        end
      end else if (count_ev_s) begin
        if (SAT_EN && (count_r == CNT_MIN)) begin
          count_nxt_s = count_r;
        end else begin
          count_nxt_s = count_r - CNT_ONE;
        end
      end else begin
        count_nxt_s = count_r;
      end
    end

    // Channel state registers; clr only touches count and err, reset wins over all.
    always_ff @(posedge MAX10_CLK1_50) begin
      if (reset) begin
        s1_r    <= 2'b00;
        s2_r    <= 2'b00;
        ab_r    <= 2'b00;
        fcnt_r  <= FCNT_ZERO;
        init_r  <= 1'b1;
        count_r <= CNT_ZERO;
        step_r  <= 1'b0;
        dir_r   <= 1'b0;
        err_r   <= 1'b0;
      end else begin
        s1_r   <= {enc_a[i], enc_b[i]};
        s2_r   <= s1_r;
        fcnt_r <= fcnt_nxt_s;
        if (accept_s) begin
          ab_r   <= s2_r;
          init_r <= 1'b0;
        end
        step_r <= count_ev_s;
        dir_r  <= dir_nxt_s;
        if (clr[i]) begin
          count_r <= CNT_ZERO;
          err_r   <= 1'b0;
        end else begin
          count_r <= count_nxt_s;
          err_r   <= err_r | illegal_s;
        end
      end
    end

    assign count[i*COUNT_W +: COUNT_W] = count_r;
    assign step[i] = step_r;
    assign dir[i]  = dir_r;
    assign err[i]  = err_r;
  end

endmodule

// File: tb/tb_quad_encoder_multi.sv
// Self-checking bench for quad_encoder_multi. Four instances share the same
// encoder inputs: x4 wrap, x4 saturate, x1 wrap and x2 wrap. A transition-level
// reference model tracks every instance's expected count, dir, err and step.
module tb_quad_encoder_multi;

  localparam int NI = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  enc_a;
  logic [1:0]  enc_b;
  logic [1:0]  clr;
  logic [15:0] cnt_o  [NI];
  logic [1:0]  step_o [NI];
  logic [1:0]  dir_o  [NI];
  logic [1:0]  err_o  [NI];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int         m_cnt [NI][2];
  bit         m_dir [NI][2];
  bit         m_err [NI][2];
  logic [1:0] m_ab  [2];
  int         res_t [NI] = '{4, 4, 1, 2};
  int         sat_t [NI] = '{0, 1, 0, 0};
  logic [1:0] seq   [4]  = '{2'b00, 2'b10, 2'b11, 2'b01};

  always #10 clk = ~clk;

  quad_encoder_multi #(.NUM_CH(2), .COUNT_W(8), .FILTER_LEN(4), .RESOLUTION(4), .SATURATE(0)) u_x4w (
    .MAX10_CLK1_50(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .clr(clr),
    .count(cnt_o[0]), .step(step_o[0]), .dir(dir_o[0]), .err(err_o[0]));
  quad_encoder_multi #(.NUM_CH(2), .COUNT_W(8), .FILTER_LEN(4), .RESOLUTION(4), .SATURATE(1)) u_x4s (
    .MAX10_CLK1_50(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .clr(clr),
    .count(cnt_o[1]), .step(step_o[1]), .dir(dir_o[1]), .err(err_o[1]));
  quad_encoder_multi #(.NUM_CH(2), .COUNT_W(8), .FILTER_LEN(4), .RESOLUTION(1), .SATURATE(0)) u_x1w (
    .MAX10_CLK1_50(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .clr(clr),
    .count(cnt_o[2]), .step(step_o[2]), .dir(dir_o[2]), .err(err_o[2]));
  quad_encoder_multi #(.NUM_CH(2), .COUNT_W(8), .FILTER_LEN(4), .RESOLUTION(2), .SATURATE(0)) u_x2w (
    .MAX10_CLK1_50(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .clr(clr),
    .count(cnt_o[3]), .step(step_o[3]), .dir(dir_o[3]), .err(err_o[3]));

  function automatic int gidx(input logic [1:0] ab);
    for (int k = 0; k < 4; k++) if (seq[k] == ab) return k;
    return 0;
  endfunction

  function automatic bit counts_at(input int res, input int idx);
    if (res == 4) return 1'b1;
    if (res == 2) return (idx % 2) == 0;
    return idx == 0;
  endfunction

  function automatic int next_count(input int c, input bit up, input int sat);
    int n;
    n = up ? c + 1 : c - 1;
    if (sat != 0) begin
      if (n > 127) n = 127;
      if (n < -128) n = -128;
    end else begin
      if (n > 127) n = n - 256;
      if (n < -128) n = n + 256;
    end
    return n;
  endfunction

  // Drive a new stable AB on one channel, check step every cycle and final state.
  task automatic drive_move(input int ch, input logic [1:0] nab, input int hold, input string tag);
    int d;
    bit exp_step [NI];
    logic [1:0] es;
    logic [7:0] want;
    int tmp;
    d = (gidx(nab) - gidx(m_ab[ch]) + 4) % 4;
    for (int i = 0; i < NI; i++) begin
      exp_step[i] = 1'b0;
      if (d == 1 || d == 3) begin
        m_dir[i][ch] = (d == 1);
        if (counts_at(res_t[i], gidx(nab))) begin
          exp_step[i] = 1'b1;
          m_cnt[i][ch] = next_count(m_cnt[i][ch], d == 1, sat_t[i]);
        end
      end else if (d == 2) begin
        m_err[i][ch] = 1'b1;
      end
    end
    m_ab[ch] = nab;
    enc_a[ch] = nab[1];
    enc_b[ch] = nab[0];
    for (int k = 1; k <= hold; k++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NI; i++) begin
        es = 2'b00;
        if (k == 6 && exp_step[i]) es[ch] = 1'b1;
        n_checks++;
        if (step_o[i] !== es) begin
          n_fail++;
          $display("FAIL %s step inst%0d cyc%0d: got %b want %b", tag, i, k, step_o[i], es);
        end
      end
    end
    for (int i = 0; i < NI; i++) begin
      for (int c = 0; c < 2; c++) begin
        tmp = m_cnt[i][c];
        want = tmp[7:0];
        n_checks++;
        if (cnt_o[i][c*8 +: 8] !== want || dir_o[i][c] !== m_dir[i][c] || err_o[i][c] !== m_err[i][c]) begin
          n_fail++;
          $display("FAIL %s state inst%0d ch%0d: got cnt=%h dir=%b err=%b want cnt=%h dir=%b err=%b",
                   tag, i, c, cnt_o[i][c*8 +: 8], dir_o[i][c], err_o[i][c], want, m_dir[i][c], m_err[i][c]);
        end
      end
    end
  endtask

  // One-cycle clr pulse on a channel; count and err of that channel must drop to 0.
  task automatic pulse_clr(input int ch, input string tag);
    logic [7:0] want;
    int tmp;
    clr[ch] = 1'b1;
    @(posedge clk); #1;
    clr[ch] = 1'b0;
    for (int i = 0; i < NI; i++) begin
      m_cnt[i][ch] = 0;
      m_err[i][ch] = 1'b0;
    end
    for (int i = 0; i < NI; i++) begin
      for (int c = 0; c < 2; c++) begin
        tmp = m_cnt[i][c];
        want = tmp[7:0];
        n_checks++;
        if (cnt_o[i][c*8 +: 8] !== want || err_o[i][c] !== m_err[i][c]) begin
          n_fail++;
          $display("FAIL %s clr inst%0d ch%0d: got cnt=%h err=%b want cnt=%h err=%b",
                   tag, i, c, cnt_o[i][c*8 +: 8], err_o[i][c], want, m_err[i][c]);
        end
      end
    end
  endtask

  // Hold reset with both channels at ab, release, and check a quiet lock-on.
  task automatic apply_reset(input logic [1:0] ab, input int ncyc, input string tag);
    reset = 1'b1;
    enc_a = {ab[1], ab[1]};
    enc_b = {ab[0], ab[0]};
    repeat (ncyc) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    for (int i = 0; i < NI; i++) begin
      for (int c = 0; c < 2; c++) begin
        m_cnt[i][c] = 0;
        m_dir[i][c] = 1'b0;
        m_err[i][c] = 1'b0;
      end
    end
    m_ab[0] = ab;
    m_ab[1] = ab;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NI; i++) begin
        n_checks++;
        if (cnt_o[i] !== 16'h0000 || step_o[i] !== 2'b00 || dir_o[i] !== 2'b00 || err_o[i] !== 2'b00) begin
          n_fail++;
          $display("FAIL %s idle inst%0d cyc%0d: got cnt=%h step=%b dir=%b err=%b want all zero",
                   tag, i, k, cnt_o[i], step_o[i], dir_o[i], err_o[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    apply_reset(2'b00, 3, "reset");
  endtask

  task automatic test_forward();
    drive_move(0, 2'b10, 10, "fwd1");
    drive_move(0, 2'b11, 10, "fwd2");
    drive_move(0, 2'b01, 10, "fwd3");
    drive_move(0, 2'b00, 10, "fwd4");
  endtask

  task automatic test_reverse();
    pulse_clr(0, "rev_clr");
    drive_move(0, 2'b01, 10, "rev1");
    drive_move(0, 2'b11, 10, "rev2");
    drive_move(0, 2'b10, 10, "rev3");
    drive_move(0, 2'b00, 10, "rev4");
  endtask

  // A pulse shorter than the filter must leave everything untouched.
  task automatic test_glitch();
    logic [7:0] want;
    int tmp;
    enc_a[0] = ~m_ab[0][1];
    repeat (3) begin
      @(posedge clk); #1;
    end
    enc_a[0] = m_ab[0][1];
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NI; i++) begin
        n_checks++;
        if (step_o[i] !== 2'b00) begin
          n_fail++;
          $display("FAIL glitch step inst%0d cyc%0d: got %b want 00", i, k, step_o[i]);
        end
      end
    end
    for (int i = 0; i < NI; i++) begin
      tmp = m_cnt[i][0];
      want = tmp[7:0];
      n_checks++;
      if (cnt_o[i][7:0] !== want) begin
        n_fail++;
        $display("FAIL glitch count inst%0d: got %h want %h", i, cnt_o[i][7:0], want);
      end
    end
    // next legal step proves the filtered state did not move
    drive_move(0, seq[(gidx(m_ab[0]) + 1) % 4], 10, "glitch_after");
  endtask

  // 128 forward steps from 0: x4 wrap goes 127 -> -128, x4 saturate holds 127.
  task automatic test_wrap();
    pulse_clr(0, "wrap_clr");
    for (int n = 0; n < 128; n++) begin
      drive_move(0, seq[(gidx(m_ab[0]) + 1) % 4], 8, "wrap");
    end
  endtask

  task automatic test_illegal();
    drive_move(0, seq[(gidx(m_ab[0]) + 2) % 4], 10, "illegal");
    drive_move(0, seq[(gidx(m_ab[0]) + 1) % 4], 10, "sticky1");
    drive_move(0, seq[(gidx(m_ab[0]) + 3) % 4], 10, "sticky2");
    pulse_clr(0, "illegal_clr");
  endtask

  task automatic test_reset_mid();
    apply_reset(2'b11, 2, "reset_mid");
    drive_move(0, 2'b01, 10, "mid_11_01");
    drive_move(0, 2'b00, 10, "mid_01_00");
    drive_move(1, 2'b10, 10, "mid_ch1_back");
  endtask

  task automatic test_random();
    int ch;
    int r;
    for (int n = 0; n < 150; n++) begin
      ch = $urandom_range(0, 1);
      r  = $urandom_range(0, 9);
      if (r == 0) begin
        pulse_clr(ch, "rnd_clr");
      end else if (r == 1) begin
        drive_move(ch, seq[(gidx(m_ab[ch]) + 2) % 4], $urandom_range(8, 12), "rnd_illegal");
      end else if (r < 6) begin
        drive_move(ch, seq[(gidx(m_ab[ch]) + 1) % 4], $urandom_range(8, 12), "rnd_fwd");
      end else begin
        drive_move(ch, seq[(gidx(m_ab[ch]) + 3) % 4], $urandom_range(8, 12), "rnd_back");
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    enc_a = 2'b00;
    enc_b = 2'b00;
    clr   = 2'b00;
    test_reset();
    test_forward();
    test_reverse();
    test_glitch();
    test_wrap();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
